sseg_scan_driver: RTL
=====================

# sseg_scan_driver

Parametrised, time-multiplexed hexadecimal seven-segment display driver for N common-anode digits. It captures a packed nibble vector into a shadow register on a load strobe, then scans the digits one at a time at a programmable rate. Each displayed nibble is decoded to active-low segments, with optional leading-zero suppression. It sits between the datapath and the board's shared segment bus and per-digit anode lines, and replaces per-digit combinational decoders.

## Interface
- N_DIGITS, 4, number of digits scanned; legal range 1..8
- CLK_DIV, 50000, clock cycles each digit stays active; legal range >= 1
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- value  input  4*N_DIGITS  packed nibbles; value[3:0] is digit 0 (rightmost)
- load  input  1  when 1 at a clock edge, value is copied into the shadow register
- lz_en  input  1  leading-zero suppression enable
- sseg  output  [0:6]  active-low segments, ordered g,f,e,d,c,b,a (sseg[6] = segment a)
- an  output  N_DIGITS  active-low digit enables; an[i] = 0 selects digit i

## Operation
- **Shadow register.** The shadow register is 4*N_DIGITS bits wide. It is loaded only when load = 1. The display always shows the shadow register, never value directly.
- **Prescaler.** tick_cnt counts 0..CLK_DIV-1 and wraps to 0. Width is max(1, $clog2(CLK_DIV)).
  - step = (tick_cnt == CLK_DIV-1).
  - When CLK_DIV = 1, step is 1 every cycle.
- **Digit index.** idx counts 0..N_DIGITS-1.
  - On step, idx advances by 1. At N_DIGITS-1 it wraps to 0.
  - When N_DIGITS = 1, idx stays 0.
- **Decode** of the selected nibble (shadow[4*idx +: 4]) to sseg:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- **Leading-zero suppression.** When lz_en = 1, digit i > 0 is blanked if nibble i and every higher nibble are 0.
  - Digit 0 is never blanked, so an all-zero value shows "0".
  - A blanked digit drives sseg = 1111111 while its anode is still driven low, which keeps the scan duty cycle constant.
- **Output registers.** sseg and an are registered. Each cycle they are computed from the current idx, shadow, and lz_en.
  - an = all ones except bit idx, which is 0.
  - Exactly one an bit is low at any time after the first post-reset edge.

## Timing
- **Reset values** (asserted asynchronously, held while rst = 1):
  - tick_cnt = 0, idx = 0, shadow = 0.
  - sseg = 1111111 (all segments off).
  - an = all ones (all digits off).
- **First cycle after reset.** At the first rising edge after rst deasserts, an = ~1 (digit 0 selected) and sseg = 1000000.
- **Load latency.** load sampled at edge k updates shadow at edge k. The new value reaches sseg/an at edge k+1. load has no effect on tick_cnt or idx.
- **Load during scan.** The digit currently shown switches to its new nibble mid-slot at edge k+1, with no glitch beyond that single cycle boundary.
- **Scan timing.** Each digit is active for exactly CLK_DIV cycles. The full scan period is N_DIGITS*CLK_DIV cycles.
  - idx changes at the edge where step = 1.
  - an/sseg reflect the new idx one edge later.
- **lz_en** is sampled every cycle. A change is visible on sseg at the next edge.
- **Reset mid-scan** immediately forces the reset values. Scanning restarts at digit 0 with a full CLK_DIV slot.
- There is no handshake. value is ignored whenever load = 0.

## Test plan
- **Reset and first digit.** N_DIGITS=4, CLK_DIV=4. Assert rst, release, no load.
  - During rst: sseg=1111111, an=1111.
  - First edge after release: an=1110, sseg=1000000.
- **Scan order.** Load value=16'h3A7F once, lz_en=0.
  - an goes 1110,1101,1011,0111,1110, each held 4 cycles.
  - sseg per digit: 0001110 (F), 1111000 (7), 0001000 (A), 0110000 (3).
- **Leading-zero suppression.** Load 16'h0050, lz_en=1.
  - Digits 3 and 2 show 1111111 while their anodes are low.
  - Digit 1 shows 0010010; digit 0 shows 1000000.
  - Load 16'h0000: digit 0 shows 1000000, the others are blank.
- **Load mid-slot.** While digit 0 shows F, load 16'h0001.
  - The edge after load: sseg=1111001.
  - idx and tick_cnt continue unchanged.
- **Async reset mid-scan.** Assert rst between edges while idx=2.
  - Outputs go to reset values before the next edge.
  - After release, digit 0 is held for the full 4 cycles.
- **Degenerate parameters.** Scenario A: N_DIGITS=1, CLK_DIV=1, load 4'hE.
  - an stays 0 and sseg stays 0000110 every cycle.
  - Scenario B: with N_DIGITS=8, idx wraps 7 -> 0.

Source files
------------

// File: rtl/sseg_scan_if.sv
// Datapath-facing bundle of the seven-segment scan driver:
// nibble vector, load strobe and the segment/anode lines.
interface sseg_scan_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] value;
    logic                  load;
    logic                  lz_en;
    logic [0:6]            sseg;
    logic [N_DIGITS-1:0]   an;

    modport master (
        output value, load, lz_en,
        input  sseg, an
    );

    modport slave (
        input  value, load, lz_en,
        output sseg, an
    );
endinterface

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed hex seven-segment driver for N common-anode digits
// with shadow register, programmable scan rate and leading-zero blanking.
module sseg_scan_driver #(
    parameter int N_DIGITS = 4,
    parameter int CLK_DIV  = 50000
) (
    input  logic         clk,
    input  logic         rst,
    sseg_scan_if.slave   bus
);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [TW-1:0]         tick_q, tick_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic [0:6]            sseg_q, sseg_d;
    logic [N_DIGITS-1:0]   an_q, an_d;

    logic       step;
    logic [3:0] nib;
    logic       blank;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign step = (tick_q == TW'(CLK_DIV - 1));

    always_comb begin
        tick_d   = step ? '0 : tick_q + 1'b1;
        idx_d    = idx_q;
        if (step) begin
            idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        shadow_d = bus.load ? bus.value : shadow_q;
    end

    // Digit i > 0 blanks when it and all higher nibbles are zero.
    always_comb begin
        nib   = 4'h0;
        blank = 1'b0;
        an_d  = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib     = shadow_q[4*i +: 4];
                blank   = (i != 0) && ((shadow_q >> (4*i)) == '0);
                an_d[i] = 1'b0;
            end
        end
        sseg_d = (bus.lz_en && blank) ? 7'h7F : seg_of(nib);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q   <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            sseg_q   <= 7'h7F;
            an_q     <= '1;
        end else begin
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            sseg_q   <= sseg_d;
            an_q     <= an_d;
        end
    end

    assign bus.sseg = sseg_q;
    assign bus.an   = an_q;
endmodule
